mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: 32-bit iterative multiply/divide unit with HI/LO result registers.
// Multiplies use shift-add and divides use restoring shift-subtract, one bit per
// cycle for 32 cycles. Signed ops iterate on magnitudes and fix the signs at the end.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state_q;
  logic [2:0]  op_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic        isSigned;
  logic        isMul;
  logic        signDiff;
  logic [31:0] magX;
  logic [31:0] magY;
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [32:0] divShift;
  logic [32:0] divDiff;
  logic [63:0] divNext;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [31:0] resHi_d;
  logic [31:0] resLo_d;
  logic        startSigned;
  logic [31:0] inMagX;
  logic [31:0] inMagY;
  logic [63:0] accInit_d;

  function automatic logic [31:0] absVal(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Start-of-operation accumulator seed: multiplier magnitude for multiply, dividend magnitude for divide.
  always_comb begin
    startSigned = (op == OP_MULT) || (op == OP_DIV);
    inMagX      = absVal(X, startSigned & X[31]);
    inMagY      = absVal(Y, startSigned & Y[31]);
    accInit_d   = op[1] ? {32'd0, inMagX} : {32'd0, inMagY};
  end

  // One iteration of shift-add or restoring division, plus the sign-corrected final result.
  always_comb begin
    isSigned  = (op_q == OP_MULT) || (op_q == OP_DIV);
    isMul     = ~op_q[1];
    signDiff  = x_q[31] ^ y_q[31];
    magX      = absVal(x_q, isSigned & x_q[31]);
    magY      = absVal(y_q, isSigned & y_q[31]);

    mulSum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, magX} : 33'd0);
    mulNext   = {mulSum, acc_q[31:1]};

    divShift  = acc_q[63:31];
    divDiff   = divShift - {1'b0, magY};
    divNext   = divDiff[32] ? {divShift[31:0], acc_q[30:0], 1'b0}
                            : {divDiff[31:0],  acc_q[30:0], 1'b1};

    product   = (isSigned && signDiff) ? (~mulNext + 64'd1) : mulNext;
    quotient  = divNext[31:0];
    remainder = divNext[63:32];

    resHi_d   = 32'd0;
    resLo_d   = 32'd0;
    if (isMul) begin
      resHi_d = product[63:32];
      resLo_d = product[31:0];
    end else if (y_q == 32'd0) begin
      resHi_d = x_q;
      resLo_d = 32'hFFFF_FFFF;
    end else begin
      resLo_d = (isSigned && signDiff) ? (~quotient + 32'd1) : quotient;
      resHi_d = (isSigned && x_q[31]) ? (~remainder + 32'd1) : remainder;
    end
  end

  // Control FSM with registered busy/done, operand latching and HI/LO updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_q    <= op;
                x_q     <= X;
                y_q     <= Y;
                cnt_q   <= 5'd0;
                acc_q   <= accInit_d;
                state_q <= CALC;
                busy_q  <= 1'b1;
              end
              OP_MTHI: hi_q <= X;
              OP_MTLO: lo_q <= X;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc_q <= isMul ? mulNext : divNext;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            hi_q    <= resHi_d;
            lo_q    <= resLo_d;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
